// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial adder FSM states and counter sizing.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_add_state_t;

   // Bit-counter width for a WIDTH-bit serial operation (CNT_W = $clog2(WIDTH)).
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder used by the bit-serial datapath.
module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic carry_o
);

   assign sum_o   = a_i ^ b_i ^ c_i;
   assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, parallel load and parallel result
// with a one-cycle done strobe.
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   serial_add_state_t state_q;
   logic [WIDTH-1:0]  sa_q, sb_q, ss_q, sum_q;
   logic [WIDTH-1:0]  sa_d, sb_d, ss_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, busy_q, done_q, cout_q, ovf_q;
   logic              cell_sum_s, cell_carry_s;

   full_adder_cell u_cell (
      .a_i     (sa_q[0]),
      .b_i     (sb_q[0]),
      .c_i     (carry_q),
      .sum_o   (cell_sum_s),
      .carry_o (cell_carry_s)
   );

   always_comb begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      ss_d  = {cell_sum_s, ss_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  carry_q <= cin;
                  ss_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sa_q    <= sa_d;
               sb_q    <= sb_d;
               ss_q    <= ss_d;
               carry_q <= cell_carry_s;
               cnt_q   <= cnt_d;
               // On the MSB cycle carry_q is the carry into the MSB, so ovf is its XOR with cout.
               if (cnt_q == LAST_BIT) begin
                  sum_q   <= ss_d;
                  cout_q  <= cell_carry_s;
                  ovf_q   <= carry_q ^ cell_carry_s;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed scenarios and a
// 4-bit instance for an exhaustive sweep.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       start = 1'b0, cin = 1'b0;
   logic [7:0] a = 8'd0, b = 8'd0;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   logic       start4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = 4'd0, b4 = 4'd0;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] sum4;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference: unsigned sum with carry, overflow from a signed range check.
   function automatic exp_t model(input int w, input int x, input int y, input int c);
      exp_t e;
      int   full, half, xs, ys, s;
      full   = x + y + c;
      half   = 1 << (w - 1);
      e.sum  = 8'(full % (1 << w));
      e.cout = (full >= (1 << w));
      xs     = (x >= half) ? x - (1 << w) : x;
      ys     = (y >= half) ? y - (1 << w) : y;
      s      = xs + ys + c;
      e.ovf  = (s > half - 1) || (s < -half);
      return e;
   endfunction

   task automatic do_op8(input string name, input logic [7:0] x, input logic [7:0] y, input logic c);
      exp_t e;
      int   lat = 0, busy_n = 0;
      bit   got = 1'b0;
      q.push_back(model(8, int'(x), int'(y), int'(c)));
      @(negedge clk);
      start = 1'b1; a = x; b = y; cin = c;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_n++;
         if (done) begin got = 1'b1; lat = i; end
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s timeout: done never seen within 40 cycles", name);
         q.delete();
      end else begin
         e = q.pop_front();
         n_tests += 5;
         if (sum !== e.sum) begin n_fail++; $display("FAIL %s sum: got %h expected %h", name, sum, e.sum); end
         if (cout !== e.cout) begin n_fail++; $display("FAIL %s cout: got %b expected %b", name, cout, e.cout); end
         if (ovf !== e.ovf) begin n_fail++; $display("FAIL %s ovf: got %b expected %b", name, ovf, e.ovf); end
         if (lat !== 9) begin n_fail++; $display("FAIL %s latency: got %0d expected 9", name, lat); end
         if (busy_n !== 8) begin n_fail++; $display("FAIL %s busy cycles: got %0d expected 8", name, busy_n); end
         @(negedge clk);
         n_tests += 2;
         if (done !== 1'b0) begin n_fail++; $display("FAIL %s done width: got %b expected 0", name, done); end
         if (sum !== e.sum) begin n_fail++; $display("FAIL %s sum hold: got %h expected %h", name, sum, e.sum); end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests += 2;
      if ({busy, done, sum, cout, ovf} !== 12'd0) begin
         n_fail++; $display("FAIL reset8: got %h expected 000", {busy, done, sum, cout, ovf});
      end
      if ({busy4, done4, sum4, cout4, ovf4} !== 8'd0) begin
         n_fail++; $display("FAIL reset4: got %h expected 00", {busy4, done4, sum4, cout4, ovf4});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_op8("add_3c_05", 8'h3C, 8'h05, 1'b0);
      do_op8("add_ff_01", 8'hFF, 8'h01, 1'b0);
      do_op8("add_7f_01", 8'h7F, 8'h01, 1'b0);
      do_op8("add_80_80_c", 8'h80, 8'h80, 1'b1);
      do_op8("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1);
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   dones = 0;
      q.push_back(model(8, 'h10, 'h20, 0));
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (dones == 1 && q.size() > 0) begin
               e = q.pop_front();
               n_tests++;
               if (sum !== e.sum) begin n_fail++; $display("FAIL ignore sum: got %h expected %h", sum, e.sum); end
            end
         end
         start = (i == 3) ? 1'b1 : 1'b0;
         if (i == 3) begin a = 8'hAA; b = 8'h55; cin = 1'b1; end
      end
      n_tests += 2;
      if (dones !== 1) begin n_fail++; $display("FAIL ignore done count: got %0d expected 1", dones); end
      if (sum !== 8'h30) begin n_fail++; $display("FAIL ignore sum held: got %h expected 30", sum); end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      @(negedge clk);
      start = 1'b1; a = 8'hF0; b = 8'h33; cin = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_tests++;
      if ({busy, done, sum, cout, ovf} !== 12'd0) begin
         n_fail++; $display("FAIL midrst outputs: got %h expected 000", {busy, done, sum, cout, ovf});
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_tests++;
      if (dones !== 0) begin n_fail++; $display("FAIL midrst spurious done: got %0d expected 0", dones); end
      do_op8("after_rst", 8'h01, 8'h01, 1'b0);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   d1 = 0, d2 = 0, dones = 0;
      q.push_back(model(8, 'h01, 'h02, 0));
      q.push_back(model(8, 'h0F, 'h0F, 0));
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      for (int i = 1; i <= 40 && dones < 2; i++) begin
         @(negedge clk);
         if (i == 1) begin a = 8'h0F; b = 8'h0F; end
         if (done) begin
            dones++;
            if (dones == 1) d1 = i; else d2 = i;
            if (q.size() > 0) begin
               e = q.pop_front();
               n_tests++;
               if (sum !== e.sum) begin n_fail++; $display("FAIL b2b sum%0d: got %h expected %h", dones, sum, e.sum); end
            end
         end
         if (d1 > 0 && i == d1 + 1) start = 1'b0;
      end
      start = 1'b0;
      n_tests += 2;
      if (dones !== 2) begin n_fail++; $display("FAIL b2b done count: got %0d expected 2", dones); end
      if (d2 - d1 !== 9) begin n_fail++; $display("FAIL b2b spacing: got %0d expected 9", d2 - d1); end
      q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_exhaustive4();
      exp_t e;
      bit   got;
      int   lat;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int c = 0; c < 2; c++) begin
               q.push_back(model(4, x, y, c));
               @(negedge clk);
               start4 = 1'b1; a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c);
               got = 1'b0; lat = 0;
               for (int i = 1; i <= 20 && !got; i++) begin
                  @(negedge clk);
                  start4 = 1'b0;
                  if (done4) begin got = 1'b1; lat = i; end
               end
               n_tests++;
               if (!got) begin
                  n_fail++; $display("FAIL w4 timeout a=%0d b=%0d c=%0d", x, y, c);
                  q.delete();
               end else begin
                  e = q.pop_front();
                  n_tests += 3;
                  if ({cout4, sum4} !== {e.cout, e.sum[3:0]}) begin
                     n_fail++; $display("FAIL w4 sum a=%0d b=%0d c=%0d: got %b_%h expected %b_%h", x, y, c, cout4, sum4, e.cout, e.sum[3:0]);
                  end
                  if (ovf4 !== e.ovf) begin
                     n_fail++; $display("FAIL w4 ovf a=%0d b=%0d c=%0d: got %b expected %b", x, y, c, ovf4, e.ovf);
                  end
                  if (lat !== 5) begin n_fail++; $display("FAIL w4 latency: got %0d expected 5", lat); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      test_exhaustive4();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
